// File: rtl/logic_unit_reg_if.sv
// Handshake/operand bundle for logic_unit_reg: request side (InValid/Op/Acc/A/B)
// and registered result side (OutValid/F/Zero) with their ready signals.
interface logic_unit_reg_if #(
   parameter int WIDTH = 32
);
   logic             InValid;
   logic             InReady;
   logic [2:0]       Op;
   logic             Acc;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             OutValid;
   logic             OutReady;
   logic [WIDTH-1:0] F;
   logic             Zero;

   modport master (
      output InValid, Op, Acc, A, B, OutReady,
      input  InReady, OutValid, F, Zero
   );

   modport slave (
      input  InValid, Op, Acc, A, B, OutReady,
      output InReady, OutValid, F, Zero
   );
endinterface

// File: rtl/logic_unit_reg.sv
// Registered bitwise logic unit with an internal accumulator and valid/ready handshake.
// Optional accumulator clear port enabled by defining LOGIC_UNIT_ACC_CLR_EN.
module logic_unit_reg #(
   parameter int WIDTH = 32
) (
   input logic             Clk,
   input logic             Rst,
`ifdef LOGIC_UNIT_ACC_CLR_EN
   input logic             AccClr,
`endif
   logic_unit_reg_if.slave bus
);

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NAND = 3'b011,
      OP_NOR  = 3'b100,
      OP_XNOR = 3'b101,
      OP_ANDN = 3'b110,
      OP_LOAD = 3'b111
   } op_e;

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] f_q;
   logic             zero_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] r;
   logic             in_ready;
   logic             accept;

   assign in_ready     = ~out_valid_q | bus.OutReady;
   assign accept       = bus.InValid & in_ready;
   assign bus.InReady  = in_ready;
   assign bus.OutValid = out_valid_q;
   assign bus.F        = f_q;
   assign bus.Zero     = zero_q;

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      x = bus.Acc ? acc_q : bus.A;
`ifdef LOGIC_UNIT_ACC_CLR_EN
      if (AccClr && bus.Acc) x = '0;
`endif
      r = bus.B;
      case (op_e'(bus.Op))
         OP_AND:  r = x & bus.B;
         OP_OR:   r = x | bus.B;
         OP_XOR:  r = x ^ bus.B;
         OP_NAND: r = ~(x & bus.B);
         OP_NOR:  r = ~(x | bus.B);
         OP_XNOR: r = ~(x ^ bus.B);
         OP_ANDN: r = x & ~bus.B;
         OP_LOAD: r = bus.B;
      endcase
   end

   // NOTE: non-blocking updates make Acc=1 read the accumulator as it was before this edge.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         out_valid_q <= 1'b0;
         f_q         <= '0;
         zero_q      <= 1'b1;
         acc_q       <= '0;
      end else begin
`ifdef LOGIC_UNIT_ACC_CLR_EN
         if (AccClr) acc_q <= '0;
`endif
         if (accept) begin
            f_q         <= r;
            zero_q      <= (r == '0);
            acc_q       <= r;
            out_valid_q <= 1'b1;
         end else if (bus.OutReady) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_logic_unit_reg.sv
// Directed self-checking bench for logic_unit_reg at WIDTH=8; define
// LOGIC_UNIT_ACC_CLR_EN to also exercise the accumulator clear port.
module tb_logic_unit_reg;

   localparam int W = 8;

   localparam logic [W-1:0] BASIC_EXP [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hC0, 8'h3C};

   localparam logic [2:0]   B2B_OP  [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b111};
   localparam logic [W-1:0] B2B_A   [5] = '{8'h0F, 8'h10, 8'hFF, 8'h00, 8'h99};
   localparam logic [W-1:0] B2B_B   [5] = '{8'hFF, 8'h01, 8'h0F, 8'h00, 8'h5A};
   localparam logic [W-1:0] B2B_EXP [5] = '{8'h0F, 8'h11, 8'hF0, 8'hFF, 8'h5A};

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   logic_unit_reg_if #(.WIDTH(W)) bus ();

`ifdef LOGIC_UNIT_ACC_CLR_EN
   logic acc_clr;
   logic_unit_reg #(.WIDTH(W)) dut (.Clk(clk), .Rst(rst), .AccClr(acc_clr), .bus(bus.slave));
`else
   logic_unit_reg #(.WIDTH(W)) dut (.Clk(clk), .Rst(rst), .bus(bus.slave));
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic acc,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
      bus.InValid  = v;
      bus.Op       = op;
      bus.Acc      = acc;
      bus.A        = a;
      bus.B        = b;
      bus.OutReady = ordy;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      tick();
      n_checks++;
      if (bus.OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid got=%b exp=0", bus.OutValid); end
      n_checks++;
      if (bus.F !== 8'h00) begin n_fail++; $display("FAIL reset_f got=%h exp=00", bus.F); end
      n_checks++;
      if (bus.Zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b exp=1", bus.Zero); end
      n_checks++;
      if (bus.InReady !== 1'b1) begin n_fail++; $display("FAIL reset_inready got=%b exp=1", bus.InReady); end
      rst = 1'b0;
   endtask

   task automatic test_basic_ops();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 3'(i), 1'b0, 8'hF0, 8'h3C, 1'b1);
         tick();
         n_checks++;
         if (bus.F !== BASIC_EXP[i] || bus.OutValid !== 1'b1 || bus.Zero !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_op%0d got F=%h V=%b Z=%b exp F=%h V=1 Z=0", i, bus.F, bus.OutValid, bus.Zero, BASIC_EXP[i]);
         end
      end
   endtask

   task automatic test_acc_chain();
      drive(1'b1, 3'b111, 1'b0, 8'h00, 8'hFF, 1'b1);
      tick();
      n_checks++;
      if (bus.F !== 8'hFF) begin n_fail++; $display("FAIL chain_load got=%h exp=FF", bus.F); end
      drive(1'b1, 3'b110, 1'b1, 8'h00, 8'h0F, 1'b1);
      tick();
      n_checks++;
      if (bus.F !== 8'hF0) begin n_fail++; $display("FAIL chain_andn got=%h exp=F0", bus.F); end
      drive(1'b1, 3'b010, 1'b1, 8'h00, 8'hF0, 1'b1);
      tick();
      n_checks++;
      if (bus.F !== 8'h00 || bus.Zero !== 1'b1) begin
         n_fail++; $display("FAIL chain_xor got F=%h Z=%b exp F=00 Z=1", bus.F, bus.Zero);
      end
      drive(1'b1, 3'b001, 1'b1, 8'h00, 8'h81, 1'b1);
      tick();
      n_checks++;
      if (bus.F !== 8'h81 || bus.Zero !== 1'b0) begin
         n_fail++; $display("FAIL chain_or got F=%h Z=%b exp F=81 Z=0", bus.F, bus.Zero);
      end
   endtask

   task automatic test_back_pressure();
      drive(1'b1, 3'b000, 1'b0, 8'hAA, 8'hFF, 1'b1);
      tick();
      n_checks++;
      if (bus.F !== 8'hAA) begin n_fail++; $display("FAIL bp_and got=%h exp=AA", bus.F); end
      drive(1'b1, 3'b111, 1'b0, 8'h00, 8'h55, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (bus.InReady !== 1'b0) begin n_fail++; $display("FAIL bp_inready cyc%0d got=%b exp=0", i, bus.InReady); end
         tick();
         n_checks++;
         if (bus.F !== 8'hAA || bus.OutValid !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold cyc%0d got F=%h V=%b exp F=AA V=1", i, bus.F, bus.OutValid);
         end
      end
      bus.OutReady = 1'b1;
      #1;
      n_checks++;
      if (bus.InReady !== 1'b1) begin n_fail++; $display("FAIL bp_release_inready got=%b exp=1", bus.InReady); end
      tick();
      n_checks++;
      if (bus.F !== 8'h55) begin n_fail++; $display("FAIL bp_release got=%h exp=55", bus.F); end
      // The stalled LOAD was taken exactly once, so the accumulator must now hold 55.
      drive(1'b1, 3'b010, 1'b1, 8'h00, 8'h00, 1'b1);
      tick();
      n_checks++;
      if (bus.F !== 8'h55) begin n_fail++; $display("FAIL bp_acc got=%h exp=55", bus.F); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, B2B_OP[i], 1'b0, B2B_A[i], B2B_B[i], 1'b1);
         #1;
         n_checks++;
         if (bus.InReady !== 1'b1) begin n_fail++; $display("FAIL b2b_inready op%0d got=%b exp=1", i, bus.InReady); end
         tick();
         n_checks++;
         if (bus.F !== B2B_EXP[i] || bus.OutValid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_op%0d got F=%h V=%b exp F=%h V=1", i, bus.F, bus.OutValid, B2B_EXP[i]);
         end
      end
      drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00, 1'b1);
      tick();
      n_checks++;
      if (bus.OutValid !== 1'b0 || bus.F !== 8'h5A) begin
         n_fail++; $display("FAIL drain got V=%b F=%h exp V=0 F=5A", bus.OutValid, bus.F);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 3'b000, 1'b0, 8'hAA, 8'hFF, 1'b0);
      tick();
      drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      n_checks++;
      if (bus.F !== 8'hAA || bus.OutValid !== 1'b1) begin
         n_fail++; $display("FAIL rmid_stall got F=%h V=%b exp F=AA V=1", bus.F, bus.OutValid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (bus.OutValid !== 1'b0 || bus.F !== 8'h00 || bus.Zero !== 1'b1) begin
         n_fail++; $display("FAIL rmid_reset got V=%b F=%h Z=%b exp V=0 F=00 Z=1", bus.OutValid, bus.F, bus.Zero);
      end
      drive(1'b1, 3'b001, 1'b1, 8'hFF, 8'h01, 1'b1);
      tick();
      n_checks++;
      if (bus.F !== 8'h01) begin n_fail++; $display("FAIL rmid_acc got=%h exp=01", bus.F); end
   endtask

`ifdef LOGIC_UNIT_ACC_CLR_EN
   task automatic test_acc_clr();
      drive(1'b1, 3'b111, 1'b0, 8'h00, 8'hFF, 1'b1);
      tick();
      acc_clr = 1'b1;
      drive(1'b1, 3'b001, 1'b1, 8'h00, 8'h12, 1'b1);
      tick();
      acc_clr = 1'b0;
      n_checks++;
      if (bus.F !== 8'h12) begin n_fail++; $display("FAIL clr_accept got=%h exp=12", bus.F); end
      drive(1'b1, 3'b001, 1'b1, 8'h00, 8'h00, 1'b1);
      tick();
      n_checks++;
      if (bus.F !== 8'h12) begin n_fail++; $display("FAIL clr_acc_write got=%h exp=12", bus.F); end
      acc_clr = 1'b1;
      drive(1'b0, 3'b000, 1'b0, 8'h00, 8'h00, 1'b1);
      tick();
      acc_clr = 1'b0;
      n_checks++;
      if (bus.F !== 8'h12) begin n_fail++; $display("FAIL clr_alone_f got=%h exp=12", bus.F); end
      drive(1'b1, 3'b001, 1'b1, 8'h00, 8'h00, 1'b1);
      tick();
      n_checks++;
      if (bus.F !== 8'h00 || bus.Zero !== 1'b1) begin
         n_fail++; $display("FAIL clr_alone_acc got F=%h Z=%b exp F=00 Z=1", bus.F, bus.Zero);
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
`ifdef LOGIC_UNIT_ACC_CLR_EN
      acc_clr  = 1'b0;
`endif
      test_reset();
      test_basic_ops();
      test_acc_chain();
      test_back_pressure();
      test_back_to_back();
      test_reset_mid();
`ifdef LOGIC_UNIT_ACC_CLR_EN
      test_acc_clr();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
